// File: rtl/estructura_inicial.sv
// rtl/estructura_inicial.sv - registered half-adder pre-processing stage of an 8-bit Brent-Kung adder
module estructura_inicial (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum,
  output logic [7:0] c
);

  logic [7:0] p;
  logic [7:0] g;

  // Eight independent half-adder slices; no carry chaining here
  always_comb begin
    p = a ^ b;
    g = a & b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= 8'h00;
      c   <= 8'h00;
    end else begin
      sum <= p;
      c   <= g;
    end
  end

endmodule

// File: tb/tb_estructura_inicial.sv
// tb/tb_estructura_inicial.sv - self-checking bench for estructura_inicial against an arithmetic model
module tb_estructura_inicial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a   = 8'h00;
  logic [7:0] b   = 8'h00;
  logic [7:0] sum;
  logic [7:0] c;

  int checks = 0;
  int passes = 0;

  // Model state: the outputs the registers must hold after the latest edge
  bit       model_valid = 1'b0;
  bit       model_rst   = 1'b0;
  int       exp_s = 0;
  int       exp_c = 0;
  int       total = 0;

  estructura_inicial dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .sum (sum),
    .c   (c)
  );

  always #5 clk = ~clk;

  // Expected value derived from the sum identity: carry bits are what remains of a+b after a^b
  always @(posedge clk) begin
    if (rst) begin
      model_valid = 1'b1;
      model_rst   = 1'b1;
      exp_s = 0;
      exp_c = 0;
      total = 0;
    end else begin
      model_rst = 1'b0;
      total = int'(a) + int'(b);
      exp_s = int'(a ^ b);
      exp_c = (total - exp_s) / 2;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      chk("model_sum", int'(sum), exp_s);
      chk("model_carry", int'(c), exp_c);
      chk("half_adder_excl", int'(sum & c), 0);
      if (!model_rst)
        chk("identity", int'(sum) + 2 * int'(c), total);
    end
  end

  task automatic cyc(input logic [7:0] ra, input logic [7:0] rb, input logic rr);
    a = ra;
    b = rb;
    rst = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [7:0] es, input logic [7:0] ec);
    chk({name, "_sum"}, int'(sum), int'(es));
    chk({name, "_c"}, int'(c), int'(ec));
  endtask

  logic [7:0] tab_a [0:9] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h03, 8'hAA, 8'hF0};
  logic [7:0] tab_b [0:9] = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h05, 8'h55, 8'h3C};
  logic [7:0] tab_s [0:9] = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h06, 8'hFF, 8'hCC};
  logic [7:0] tab_c [0:9] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h01, 8'h00, 8'h30};

  initial begin
    // Reset with all-ones operands must not leak into the outputs
    a = 8'hFF;
    b = 8'hFF;
    rst = 1'b1;
    @(posedge clk);
    #1;
    lit("reset0", 8'h00, 8'h00);
    cyc(8'hFF, 8'hFF, 1'b1);
    lit("reset1", 8'h00, 8'h00);
    cyc(8'hFF, 8'hFF, 1'b0);
    lit("after_reset", 8'h00, 8'hFF);

    for (int i = 0; i < 10; i++) begin
      cyc(tab_a[i], tab_b[i], 1'b0);
      lit($sformatf("table%0d", i), tab_s[i], tab_c[i]);
    end

    // Back-to-back random pairs, checked by the per-cycle compare process
    for (int i = 0; i < 12000; i++)
      cyc(8'($urandom), 8'($urandom), 1'b0);

    // Reset in the middle of a stream discards the pair sampled on that edge
    cyc(8'h5A, 8'hC3, 1'b0);
    lit("pre_midreset", 8'h99, 8'h42);
    cyc(8'hFF, 8'hFF, 1'b1);
    lit("midreset", 8'h00, 8'h00);
    cyc(8'h81, 8'h81, 1'b0);
    lit("post_midreset", 8'h00, 8'h81);

    for (int i = 0; i < 16; i++)
      cyc(8'($urandom), 8'($urandom), 1'b0);

    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
